// File: rtl/pcie_link_pkg.sv
// PCIe link channel shared types and constants.
// Symbol codes, FSM states and the FIFO entry layout.
package pcie_link_pkg;

  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] COM = 8'hBC;
  localparam int ENTRY_W = 10;

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  typedef struct packed {
    logic       elecIdle;
    logic       dataK;
    logic [7:0] data;
  } entry_t;

  function automatic logic isSkp(input entry_t e);
    return e.dataK && (e.data == SKP);
  endfunction

endpackage

// File: rtl/pcie_link_fifo.sv
// Circular symbol buffer for the link channel.
// Read data is combinational from the read pointer.
module pcie_link_fifo
  import pcie_link_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               pclk,
  input  logic               nreset,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [AW:0]        occupancy,
  output logic               full,
  output logic               empty
);

  localparam int OW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wrPtr;
  logic [AW-1:0]      rdPtr;
  logic               doWr;
  logic               doRd;

  assign full    = occupancy == OW'(DEPTH);
  assign empty   = occupancy == '0;
  assign doRd    = rd_en && !empty;
  assign doWr    = wr_en && (!full || doRd);
  assign rd_data = mem[rdPtr];

  always_ff @(posedge pclk) begin
    if (doWr) mem[wrPtr] <= wr_data;
  end

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + 1'b1;
      if (doRd) rdPtr <= rdPtr + 1'b1;
      occupancy <= occupancy + OW'(doWr) - OW'(doRd);
    end
  end

endmodule

// File: rtl/pcie_link_chan.sv
// PIPE-level link channel: programmable latency, error
// injection and SKP deletion/insertion between two PHYs.
module pcie_link_chan
  import pcie_link_pkg::*;
#(
  parameter int MAX_DELAY = 16,
  parameter int DW        = $clog2(MAX_DELAY)
) (
  input  logic          pclk,
  input  logic          nreset,
  input  logic [7:0]    TxData,
  input  logic          TxDataK,
  input  logic          ElecIdleIn,
  input  logic [DW-1:0] Delay,
  input  logic          InjErr,
  input  logic [7:0]    ErrMask,
  input  logic          SkpDel,
  input  logic          SkpIns,
  output logic [7:0]    RxData,
  output logic          RxDataK,
  output logic          ElecIdleOut,
  output logic [15:0]   ErrCnt,
  output logic          Overflow,
  output logic          Underflow
);

  localparam int AW = $clog2(MAX_DELAY);
  localparam int OW = AW + 1;

  state_t             state;
  logic               errArmed;
  logic               delArmed;
  logic               insArmed;
  entry_t             inEntry;
  entry_t             wrEntry;
  entry_t             rdEntry;
  logic [ENTRY_W-1:0] rdData;
  logic [AW:0]        occ;
  logic [AW:0]        occNext;
  logic [AW:0]        dlyEff;
  logic               full;
  logic               empty;
  logic               eligible;
  logic               corrupt;
  logic               dropSkp;
  logic               wrReq;
  logic               wrEn;
  logic               rdTry;
  logic               hold;
  logic               rdEn;
  logic               ovfNow;
  logic               unfNow;

  always_comb begin
    inEntry  = '{elecIdle: ElecIdleIn, dataK: TxDataK, data: TxData};
    rdEntry  = entry_t'(rdData);
    eligible = !TxDataK && !ElecIdleIn;
    dropSkp  = delArmed && isSkp(inEntry);
    wrReq    = !dropSkp;
    rdTry    = state == RUN;
    // Inserting a SKP = re-reading the same entry once
    hold     = rdTry && !empty && insArmed && isSkp(rdEntry);
    rdEn     = rdTry && !empty && !hold;
    wrEn     = wrReq && (!full || rdEn);
    ovfNow   = wrReq && full && !rdEn;
    unfNow   = rdTry && empty;
    corrupt  = (errArmed || InjErr) && eligible && wrEn;
    wrEntry  = inEntry;
    if (corrupt) wrEntry.data = TxData ^ ErrMask;
    occNext  = occ + OW'(wrEn) - OW'(rdEn);
    dlyEff   = (Delay == '0) ? OW'(1) : OW'(Delay);
  end

  pcie_link_fifo #(
    .DEPTH(MAX_DELAY)
  ) uFifo (
    .pclk     (pclk),
    .nreset   (nreset),
    .wr_en    (wrEn),
    .rd_en    (rdEn),
    .wr_data  (wrEntry),
    .rd_data  (rdData),
    .occupancy(occ),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      state       <= PRIME;
      errArmed    <= 1'b0;
      delArmed    <= 1'b0;
      insArmed    <= 1'b0;
      RxData      <= 8'h00;
      RxDataK     <= 1'b0;
      ElecIdleOut <= 1'b1;
      ErrCnt      <= '0;
      Overflow    <= 1'b0;
      Underflow   <= 1'b0;
    end else begin
      if (corrupt) begin
        errArmed <= 1'b0;
        if (ErrCnt != 16'hFFFF) ErrCnt <= ErrCnt + 16'd1;
      end else if (InjErr) begin
        errArmed <= 1'b1;
      end

      if (dropSkp) delArmed <= 1'b0;
      else if (SkpDel) delArmed <= 1'b1;

      if (hold) insArmed <= 1'b0;
      else if (SkpIns) insArmed <= 1'b1;

      if (ovfNow) Overflow <= 1'b1;

      unique case (state)
        PRIME: begin
          RxData      <= 8'h00;
          RxDataK     <= 1'b0;
          ElecIdleOut <= 1'b1;
          // >= so a Delay lowered below the fill still starts
          if (occNext >= dlyEff) state <= RUN;
        end
        RUN: begin
          if (unfNow) begin
            Underflow   <= 1'b1;
            RxData      <= 8'h00;
            RxDataK     <= 1'b0;
            ElecIdleOut <= 1'b1;
            state       <= PRIME;
          end else begin
            RxData      <= rdEntry.data;
            RxDataK     <= rdEntry.dataK;
            ElecIdleOut <= rdEntry.elecIdle;
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

endmodule

// File: doc/pcie_link_chan.md
PCIE_LINK_CHAN -- requirements
Module: pcie_link_chan

Interface
REQ-001 Parameter MAX_DELAY, default 16, FIFO depth in symbols; power of two, 4..64.
REQ-002 Parameter DW, default $clog2(MAX_DELAY), width of the Delay port.
REQ-003 pclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 nreset  input  1  reset, asynchronous and active-low.
REQ-005 TxData  input  8  symbol from the upstream PIPE transmitter.
REQ-006 TxDataK  input  1  K-symbol flag for TxData.
REQ-007 ElecIdleIn  input  1  upstream electrical-idle indication.
REQ-008 Delay  input  DW  target channel latency in cycles; 0 is treated as 1.
REQ-009 InjErr  input  1  single-cycle request to corrupt one data symbol.
REQ-010 ErrMask  input  8  XOR mask applied by error injection.
REQ-011 SkpDel  input  1  single-cycle request to delete one SKP symbol.
REQ-012 SkpIns  input  1  single-cycle request to insert one SKP symbol.
REQ-013 RxData  output  8  symbol to the downstream PIPE receiver, registered.
REQ-014 RxDataK  output  1  K flag for RxData, registered.
REQ-015 ElecIdleOut  output  1  delayed electrical-idle indication, registered.
REQ-016 ErrCnt  output  16  count of injected errors, saturating at 0xFFFF.
REQ-017 Overflow  output  1  sticky; a write was discarded while the FIFO was full.
REQ-018 Underflow  output  1  sticky; a read was attempted while the FIFO was empty in RUN.

Function
REQ-019 Each FIFO entry SHALL hold {ElecIdleIn, TxDataK, TxData}; one entry is written per cycle unless it is discarded (REQ-025, REQ-028).
REQ-020 The state machine SHALL have states PRIME and RUN; reset enters PRIME.
REQ-021 In PRIME: no reads occur; outputs are RxData=0x00, RxDataK=0, ElecIdleOut=1; Delay is sampled every cycle.
REQ-022 PRIME->RUN SHALL occur when occupancy equals the sampled Delay; Delay changes in RUN are ignored until the next PRIME.
REQ-023 In RUN: one entry is read per cycle into the output registers. A symbol sampled at edge n appears on RxData at edge n+Delay when no SKP adjustment has occurred.
REQ-024 RUN with an empty FIFO at a read: set Underflow, drive the PRIME output values, and return to PRIME.
REQ-025 Write while full (occupancy=MAX_DELAY with no read that cycle): discard the write and set Overflow. A simultaneous read and write at full SHALL succeed.
REQ-026 InjErr SHALL arm a one-deep flag; a second InjErr while armed is ignored.
REQ-027 While armed, the next written entry with TxDataK=0 and ElecIdleIn=0 is stored as TxData XOR ErrMask. The flag then clears and ErrCnt increments, including when ErrMask=0. If InjErr arrives in the same cycle as an eligible symbol, that symbol is corrupted.
REQ-028 SkpDel SHALL arm a one-deep flag; the next incoming SKP (TxDataK=1, TxData=0x1C) is not written, and the flag clears.
REQ-029 SkpIns SHALL arm a one-deep flag. When the next SKP is read in RUN, the read pointer holds for one cycle so the SKP is output twice, then the flag clears.
REQ-030 The SkpDel and SkpIns flags are independent, and both may act on the same ordered set.
REQ-031 K symbols and entries with ElecIdleIn=1 SHALL never be corrupted.

Reset
REQ-032 Asserting nreset SHALL immediately force: RxData=0x00, RxDataK=0, ElecIdleOut=1, ErrCnt=0, Overflow=0, Underflow=0, pointers=0, occupancy=0, all armed flags=0, state=PRIME.
REQ-033 Deassertion is sampled synchronously; the first write occurs on the first rising edge with nreset high.

Structure
REQ-034 Package pcie_link_pkg SHALL hold: SKP=8'h1C, COM=8'hBC, the state enumeration (PRIME, RUN) and the FIFO entry width (10).
REQ-035 Sub-module pcie_link_fifo SHALL implement the synchronous circular buffer. It exposes wr_en, rd_en, wr_data, rd_data, occupancy, full and empty; read data is combinational from the read pointer.
REQ-036 Control, error injection, SKP adjustment and the output registers SHALL live in pcie_link_chan.

Verification
REQ-037 Delay=4; drive 0x00..0x0F with K=0 and ElecIdleIn=0 from cycle 20 -> RxData shows 0x00..0x0F starting 4 cycles after the first sample, with ElecIdleOut=0 throughout.
REQ-038 InjErr with ErrMask=0x01 before the sequence BC(K),1C(K),1C(K),1C(K),55 -> output is BC,1C,1C,1C,54; ErrCnt=1.
REQ-039 SkpDel pulse then COM,SKP,SKP,SKP,0xAA -> output COM,SKP,SKP,0xAA; total latency is one less from then on.
REQ-040 SkpIns pulse then COM,SKP,SKP,SKP -> output COM followed by four SKPs; Delay=MAX_DELAY-1 plus two insertions -> Overflow=1.
REQ-041 Delay=2 with three consecutive SkpDel-driven deletions -> Underflow=1, ElecIdleOut=1, then re-prime and resume after 2 cycles.
REQ-042 nreset low mid-stream between clock edges -> all outputs take their reset values without waiting for a clock edge; after release, priming restarts.
